// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-serial instruction/data memory controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_RD  = 2'd1,
        MEM_RD = 2'd2,
        MEM_WR = 2'd3
    } state_e;

    localparam logic [31:0] ZERO32     = 32'h0000_0000;
    localparam logic [2:0]  WORD_BYTES = 3'd4;

    // Byte count of a load/store; anything but 1 or 2 is a full word.
    function automatic logic [2:0] len_bytes(input logic [2:0] len);
        case (len)
            3'd1:    return 3'd1;
            3'd2:    return 3'd2;
            default: return WORD_BYTES;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Fetch, load/store and byte-wide RAM signals shared by the controller and its users.
interface mem_ctrl_if;

    logic        pcJump_in;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic [31:0] if_data_out;
    logic        if_done_out;
    logic        mem_req_in;
    logic        mem_wr_in;
    logic [31:0] mem_addr_in;
    logic [2:0]  mem_len_in;
    logic [31:0] mem_wdata_in;
    logic [31:0] mem_data_out;
    logic        mem_done_out;
    logic [7:0]  ram_din_in;
    logic [7:0]  ram_dout_out;
    logic [31:0] ram_a_out;
    logic        ram_wr_out;
    logic        ifStall_out;
    logic        memStall_out;

    modport slave (
        input  pcJump_in, if_req_in, if_addr_in, mem_req_in, mem_wr_in,
               mem_addr_in, mem_len_in, mem_wdata_in, ram_din_in,
        output if_data_out, if_done_out, mem_data_out, mem_done_out,
               ram_dout_out, ram_a_out, ram_wr_out, ifStall_out, memStall_out
    );

    modport master (
        output pcJump_in, if_req_in, if_addr_in, mem_req_in, mem_wr_in,
               mem_addr_in, mem_len_in, mem_wdata_in, ram_din_in,
        input  if_data_out, if_done_out, mem_data_out, mem_done_out,
               ram_dout_out, ram_a_out, ram_wr_out, ifStall_out, memStall_out
    );

endinterface

// File: rtl/mem_ctrl.sv
// Serialises fetches and loads/stores onto a byte RAM: n-byte read done n+1 edges after accept, write after n.
// Requesters hold req until done; the stall outputs hold the pipeline meanwhile, and a load/store beats a fetch.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic      clk_in,
    input  logic      rst_in,
    mem_ctrl_if.slave bus
);

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic [2:0]  len_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf_q;
    logic [31:0] if_data_q;
    logic [31:0] mem_data_q;
    logic [31:0] ram_a_q;
    logic [7:0]  ram_dout_q;
    logic        ram_wr_q;
    logic        if_done_q;
    logic        mem_done_q;

    logic [2:0]  mem_len_d;
    logic        done_cycle_d;

    assign mem_len_d    = len_bytes(bus.mem_len_in);
    assign done_cycle_d = if_done_q | mem_done_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            len_q      <= 3'd0;
            addr_q     <= ZERO32;
            wdata_q    <= ZERO32;
            rbuf_q     <= ZERO32;
            if_data_q  <= ZERO32;
            mem_data_q <= ZERO32;
            ram_a_q    <= ZERO32;
            ram_dout_q <= 8'h00;
            ram_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
        end else begin
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            ram_wr_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    // The done cycle is a mandatory turnaround: requests still held then are not taken.
                    if (!done_cycle_d) begin
                        if (bus.mem_req_in) begin
                            addr_q  <= bus.mem_addr_in;
                            len_q   <= mem_len_d;
                            wdata_q <= bus.mem_wdata_in;
                            ram_a_q <= bus.mem_addr_in;
                            rbuf_q  <= ZERO32;
                            cnt_q   <= 3'd0;
                            if (bus.mem_wr_in) begin
                                state_q    <= MEM_WR;
                                ram_dout_q <= bus.mem_wdata_in[7:0];
                                ram_wr_q   <= 1'b1;
                            end else begin
                                state_q <= MEM_RD;
                            end
                        end else if (bus.if_req_in && !bus.pcJump_in) begin
                            addr_q  <= bus.if_addr_in;
                            len_q   <= WORD_BYTES;
                            ram_a_q <= bus.if_addr_in;
                            rbuf_q  <= ZERO32;
                            cnt_q   <= 3'd0;
                            state_q <= IF_RD;
                        end
                    end
                end
                IF_RD, MEM_RD: begin
                    if (state_q == IF_RD && bus.pcJump_in) begin
                        state_q <= IDLE;
                        cnt_q   <= 3'd0;
                    end else if (cnt_q == len_q) begin
                        state_q <= IDLE;
                        cnt_q   <= 3'd0;
                        if (state_q == IF_RD) begin
                            if_data_q <= rbuf_q;
                            if_done_q <= 1'b1;
                        end else begin
                            mem_data_q <= rbuf_q;
                            mem_done_q <= 1'b1;
                        end
                    end else begin
                        // RAM returns the byte for the previous cycle's address.
                        rbuf_q[{cnt_q[1:0], 3'b000} +: 8] <= bus.ram_din_in;
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q + 3'd1 < len_q) begin
                            ram_a_q <= addr_q + 32'(cnt_q) + 32'd1;
                        end
                    end
                end
                MEM_WR: begin
                    if (cnt_q + 3'd1 < len_q) begin
                        cnt_q      <= cnt_q + 3'd1;
                        ram_a_q    <= addr_q + 32'(cnt_q) + 32'd1;
                        ram_dout_q <= wdata_q[{cnt_q[1:0] + 2'd1, 3'b000} +: 8];
                        ram_wr_q   <= 1'b1;
                    end else begin
                        state_q    <= IDLE;
                        cnt_q      <= 3'd0;
                        mem_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.if_data_out  = if_data_q;
    assign bus.if_done_out  = if_done_q;
    assign bus.mem_data_out = mem_data_q;
    assign bus.mem_done_out = mem_done_q;
    assign bus.ram_a_out    = ram_a_q;
    assign bus.ram_dout_out = ram_dout_q;
    assign bus.ram_wr_out   = ram_wr_q;
    assign bus.ifStall_out  = bus.if_req_in & ~if_done_q;
    assign bus.memStall_out = bus.mem_req_in & ~mem_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: 4 KiB byte RAM model aliased across the address space, directed scenarios then random traffic.
module tb_mem_ctrl;

    logic clk_in;
    logic rst_in;

    mem_ctrl_if bus();

    mem_ctrl dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus.slave)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic [7:0] ram [0:4095];
    bit         ram_filled = 1'b0;

    always @(posedge clk_in) begin
        if (!ram_filled) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'($urandom);
            ram_filled <= 1'b1;
        end else if (bus.ram_wr_out) begin
            ram[bus.ram_a_out[11:0]] <= bus.ram_dout_out;
        end
    end

    assign bus.ram_din_in = ram[bus.ram_a_out[11:0]];

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_if_q    = 32'h0;
    logic [31:0] exp_mem_q   = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic int nbytes(input logic [2:0] len);
        if (len == 3'd1) return 1;
        if (len == 3'd2) return 2;
        return 4;
    endfunction

    function automatic logic [7:0] ram_at(input logic [31:0] a);
        return ram[a[11:0]];
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_if_data"},  bus.if_data_out,          32'h0);
        check({tag, "_mem_data"}, bus.mem_data_out,         32'h0);
        check({tag, "_ram_a"},    bus.ram_a_out,            32'h0);
        check({tag, "_ram_dout"}, 32'(bus.ram_dout_out),    32'h0);
        check({tag, "_ram_wr"},   32'(bus.ram_wr_out),      32'h0);
        check({tag, "_if_done"},  32'(bus.if_done_out),     32'h0);
        check({tag, "_mem_done"}, 32'(bus.mem_done_out),    32'h0);
    endtask

    task automatic do_read(input bit is_if, input logic [31:0] a, input logic [2:0] len);
        int          n;
        logic [31:0] exp_d;
        n     = is_if ? 4 : nbytes(len);
        exp_d = 32'h0;
        for (int k = 0; k < n; k++) exp_d |= 32'(ram_at(a + 32'(k))) << (8 * k);
        if (is_if) begin
            bus.if_req_in  = 1'b1;
            bus.if_addr_in = a;
            bus.pcJump_in  = 1'b0;
        end else begin
            bus.mem_req_in   = 1'b1;
            bus.mem_wr_in    = 1'b0;
            bus.mem_addr_in  = a;
            bus.mem_len_in   = len;
            bus.mem_wdata_in = $urandom;
        end
        #1;
        check("rd_stall_req", 32'(is_if ? bus.ifStall_out : bus.memStall_out), 32'h1);
        tick();
        for (int k = 0; k < n; k++) begin
            check($sformatf("rd_addr%0d", k), bus.ram_a_out, a + 32'(k));
            check("rd_wr_low", 32'(bus.ram_wr_out), 32'h0);
            check("rd_no_early_done", 32'(bus.if_done_out | bus.mem_done_out), 32'h0);
            if (!is_if) bus.pcJump_in = 1'($urandom);
            tick();
        end
        check("rd_done_not_yet", 32'(is_if ? bus.if_done_out : bus.mem_done_out), 32'h0);
        tick();
        if (is_if) begin
            check("if_done",        32'(bus.if_done_out),  32'h1);
            check("if_data",        bus.if_data_out,       exp_d);
            check("mem_data_held",  bus.mem_data_out,      exp_mem_q);
            check("if_stall_clear", 32'(bus.ifStall_out),  32'h0);
            exp_if_q       = exp_d;
            bus.if_req_in  = 1'b0;
        end else begin
            check("mem_done",        32'(bus.mem_done_out), 32'h1);
            check("mem_data",        bus.mem_data_out,      exp_d);
            check("if_data_held",    bus.if_data_out,       exp_if_q);
            check("mem_stall_clear", 32'(bus.memStall_out), 32'h0);
            exp_mem_q      = exp_d;
            bus.mem_req_in = 1'b0;
        end
        bus.pcJump_in = 1'b0;
        tick();
        check("rd_done_one_cycle", 32'(bus.if_done_out | bus.mem_done_out), 32'h0);
        check("rd_if_data_stable",  bus.if_data_out,  exp_if_q);
        check("rd_mem_data_stable", bus.mem_data_out, exp_mem_q);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [2:0] len, input logic [31:0] wd);
        int         n;
        logic [7:0] beyond;
        n      = nbytes(len);
        beyond = ram_at(a + 32'(n));
        bus.mem_req_in   = 1'b1;
        bus.mem_wr_in    = 1'b1;
        bus.mem_addr_in  = a;
        bus.mem_len_in   = len;
        bus.mem_wdata_in = wd;
        tick();
        for (int k = 0; k < n; k++) begin
            check($sformatf("wr_addr%0d", k), bus.ram_a_out, a + 32'(k));
            check($sformatf("wr_byte%0d", k), 32'(bus.ram_dout_out), 32'(wd[8*k +: 8]));
            check("wr_strobe", 32'(bus.ram_wr_out), 32'h1);
            check("wr_no_early_done", 32'(bus.mem_done_out), 32'h0);
            bus.pcJump_in = 1'($urandom);
            tick();
        end
        check("wr_done",        32'(bus.mem_done_out), 32'h1);
        check("wr_strobe_off",  32'(bus.ram_wr_out),   32'h0);
        check("wr_mem_data_held", bus.mem_data_out,    exp_mem_q);
        bus.mem_req_in = 1'b0;
        bus.mem_wr_in  = 1'b0;
        bus.pcJump_in  = 1'b0;
        tick();
        check("wr_done_one_cycle", 32'(bus.mem_done_out), 32'h0);
        for (int k = 0; k < n; k++)
            check($sformatf("wr_ram%0d", k), 32'(ram_at(a + 32'(k))), 32'(wd[8*k +: 8]));
        if (n < 4) check("wr_ram_untouched", 32'(ram_at(a + 32'(n))), 32'(beyond));
    endtask

    initial begin
        logic [7:0] b200;
        rst_in           = 1'b1;
        bus.pcJump_in    = 1'b0;
        bus.if_req_in    = 1'b0;
        bus.if_addr_in   = 32'h0;
        bus.mem_req_in   = 1'b0;
        bus.mem_wr_in    = 1'b0;
        bus.mem_addr_in  = 32'h0;
        bus.mem_len_in   = 3'd0;
        bus.mem_wdata_in = 32'h0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_in = 1'b0;
        tick();

        // Halfword store: 0x34 then 0x12.
        do_write(32'h300, 3'd2, 32'hABCD1234);

        // Instruction word 13 05 00 00 at 0x100.
        do_write(32'h100, 3'd4, 32'h00000513);
        do_read(1'b1, 32'h100, 3'd4);
        check("fetch_0x100", bus.if_data_out, 32'h00000513);

        // Simultaneous requests: the load wins, the fetch starts two edges after its done.
        b200 = ram_at(32'h200);
        bus.mem_req_in  = 1'b1;
        bus.mem_wr_in   = 1'b0;
        bus.mem_addr_in = 32'h200;
        bus.mem_len_in  = 3'd1;
        bus.if_req_in   = 1'b1;
        bus.if_addr_in  = 32'h400;
        tick();
        check("prio_addr", bus.ram_a_out, 32'h200);
        tick();
        tick();
        check("prio_mem_done", 32'(bus.mem_done_out), 32'h1);
        check("prio_mem_data", bus.mem_data_out, 32'(b200));
        check("prio_if_waits", 32'(bus.if_done_out), 32'h0);
        exp_mem_q      = 32'(b200);
        bus.mem_req_in = 1'b0;
        tick();
        check("turnaround_no_accept", bus.ram_a_out, 32'h200);
        do_read(1'b1, 32'h400, 3'd4);

        // Redirect mid-fetch, then a jump held in IDLE blocks a new fetch.
        bus.if_req_in  = 1'b1;
        bus.if_addr_in = 32'h600;
        tick();
        tick();
        tick();
        bus.pcJump_in = 1'b1;
        tick();
        check("jump_no_done", 32'(bus.if_done_out), 32'h0);
        check("jump_data_kept", bus.if_data_out, exp_if_q);
        tick();
        check("jump_blocks_accept", bus.ram_a_out, 32'h602);
        check("jump_still_no_done", 32'(bus.if_done_out), 32'h0);
        do_read(1'b1, 32'h700, 3'd4);

        // Reset part-way through a word load.
        bus.mem_req_in  = 1'b1;
        bus.mem_wr_in   = 1'b0;
        bus.mem_addr_in = 32'h500;
        bus.mem_len_in  = 3'd4;
        tick();
        tick();
        tick();
        rst_in = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst_in         = 1'b0;
        bus.mem_req_in = 1'b0;
        exp_if_q       = 32'h0;
        exp_mem_q      = 32'h0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_no_done", 32'(bus.mem_done_out | bus.if_done_out), 32'h0);
        end
        do_read(1'b0, 32'h504, 3'd4);

        // Address wrap across 2^32.
        do_read(1'b1, 32'hFFFF_FFFE, 3'd4);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic [2:0]  len;
            a   = $urandom;
            len = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0:       do_read(1'b1, a, len);
                1:       do_read(1'b0, a, len);
                default: do_write(a, len, $urandom);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have: clk_in  input  1  single system clock, rising edge.
REQ-002 SHALL have: rst_in  input  1  reset, synchronous, active-high (`rstEnable).
REQ-003 SHALL have: pcJump_in  input  1  branch/jump redirect; cancels an in-flight instruction fetch.
REQ-004 SHALL have: if_req_in  input  1  fetch request, held until if_done_out.
REQ-005 SHALL have: if_addr_in  input  32  fetch byte address.
REQ-006 SHALL have: if_data_out  output  32  fetched instruction word, little-endian.
REQ-007 SHALL have: if_done_out  output  1  one-cycle fetch completion pulse.
REQ-008 SHALL have: mem_req_in  input  1  load/store request, held until mem_done_out.
REQ-009 SHALL have: mem_wr_in  input  1  1 = store, 0 = load.
REQ-010 SHALL have: mem_addr_in  input  32  load/store byte address.
REQ-011 SHALL have: mem_len_in  input  3  byte count: 1, 2 or 4.
REQ-012 SHALL have: mem_wdata_in  input  32  store data; low mem_len_in bytes used.
REQ-013 SHALL have: mem_data_out  output  32  load data, zero-extended.
REQ-014 SHALL have: mem_done_out  output  1  one-cycle load/store completion pulse.
REQ-015 SHALL have: ram_din_in  input  8  RAM read byte, valid one cycle after its address.
REQ-016 SHALL have: ram_dout_out  output  8  RAM write byte.
REQ-017 SHALL have: ram_a_out  output  32  RAM byte address.
REQ-018 SHALL have: ram_wr_out  output  1  1 = write this cycle.
REQ-019 SHALL have: ifStall_out, memStall_out  output  1 each  stall requests to the stall controller.

Function
REQ-020 SHALL run FSM states IDLE, IF_RD, MEM_RD, MEM_WR; all transitions on the rising edge of clk_in.
REQ-021 SHALL, in IDLE, accept mem_req_in over if_req_in when both are high; MEM has fixed priority.
REQ-022 SHALL NOT accept an IF request in a cycle where pcJump_in is high.
REQ-023 SHALL, at acceptance edge E0, latch address/len/wdata/wr and drive ram_a_out = addr + 0.
REQ-024 SHALL, for an n-byte read, drive ram_a_out = addr+k after edge Ek, k = 0..n-1.
REQ-025 SHALL, for a read, capture ram_din_in into byte lane k at edge E(k+1).
REQ-026 SHALL, for a read, pulse done for the one cycle after edge E(n+1), with the data output valid in that cycle.
REQ-027 SHALL, for an n-byte write, drive ram_a_out = addr+k, ram_dout_out = byte k and ram_wr_out = 1 after Ek.
REQ-028 SHALL, for a write, pulse mem_done_out for the one cycle after edge En, with ram_wr_out = 0 in that cycle.
REQ-029 SHALL treat IF fetches as n = 4 always.
REQ-030 SHALL keep ram_wr_out = 0 in all cycles other than write bytes.
REQ-031 SHALL return to IDLE in the done cycle.
REQ-032 SHALL ignore requests in the done cycle; the earliest next acceptance is the following edge (one-cycle turnaround).
REQ-033 SHALL abort an IF_RD on pcJump_in high: go to IDLE at the next edge, with no if_done_out and if_data_out unchanged.
REQ-034 SHALL NOT let pcJump_in affect MEM_RD or MEM_WR.
REQ-035 SHALL hold if_data_out and mem_data_out stable between completions.
REQ-036 SHALL compute the stall requests combinationally: ifStall_out = if_req_in & ~if_done_out; memStall_out = mem_req_in & ~mem_done_out.
REQ-037 SHALL wrap address arithmetic modulo 2^32.
REQ-038 SHALL treat mem_len_in values other than 1/2/4 as 4.

Reset
REQ-039 SHALL, when rst_in is high at an edge, set state to IDLE and clear the byte counter.
REQ-040 SHALL, on reset, set if_data_out, mem_data_out, ram_a_out and ram_dout_out to 0.
REQ-041 SHALL, on reset, set if_done_out, mem_done_out and ram_wr_out to 0.
REQ-042 SHALL, on reset mid-transaction, abandon the transaction with no done pulse; a partially written store remains partial.

Structure
REQ-043 SHALL take from defines.vh: state encodings, `rstEnable, `Read/`Write, `addrRange/`dataRange, ZERO32.
REQ-044 SHALL be a single module with no sub-module; the byte-lane assembly is inline.

Verification
REQ-045 SHALL cover this IF fetch: if_addr_in=0x100, RAM[0x100..0x103]=13 05 00 00 -> if_data_out=0x00000513, if_done_out pulsed after E5.
REQ-046 SHALL cover simultaneous requests: if_req_in and mem_req_in (1-byte load from 0x200) high together -> MEM is served first; mem_done_out after E2; IF accepted 2 edges later.
REQ-047 SHALL cover this store: mem_wr_in=1, len=2, addr=0x300, wdata=0xABCD1234 -> writes 0x34@0x300 then 0x12@0x301, mem_done_out after E2.
REQ-048 SHALL cover a redirect: pcJump_in pulsed after E2 of a fetch -> IDLE at the next edge, no if_done_out, new fetch accepted afterwards.
REQ-049 SHALL cover mid-read reset: rst_in high mid-way through a 4-byte load -> all outputs 0, state IDLE, no mem_done_out.
REQ-050 SHALL cover address wrap: a 4-byte fetch at 0xFFFFFFFE -> ram_a_out sequence FFFFFFFE, FFFFFFFF, 0, 1.
